// File: rtl/line_feed_ctrl.sv
// Line feed controller: preloads the line buffers, then releases one source line per line-done credit.
// Optional top/bottom zero-line padding is enabled with `define LINE_FEED_PAD_EN.
module line_feed_ctrl #(
    parameter int IMG_W         = 512,
    parameter int IMG_H         = 512,
    parameter int PRELOAD_LINES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_src_data,
    input  logic       i_src_valid,
    output logic       o_src_ready,
    output logic [7:0] o_pixel_data,
    output logic       o_pixel_data_valid,
    input  logic       i_lb_intr,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_lines_sent
);

    // state        | meaning
    // S_IDLE       | waiting for i_start
    // S_PRELOAD    | forwarding the first PRELOAD_LINES lines without credits
    // S_WAIT_CREDIT| line boundary; wait for a credit, drain, or finish
    // S_SEND_LINE  | forwarding one credited line
    // S_DONE       | one-cycle completion pulse

    localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
`ifdef LINE_FEED_PAD_EN
    localparam int TOTAL_LINES = IMG_H + 2;
    localparam int ROWS        = IMG_H;
`else
    localparam int TOTAL_LINES = IMG_H;
    localparam int ROWS        = IMG_H - 2;
`endif
    localparam logic [PW-1:0] PIX_LAST    = PW'(IMG_W - 1);
    localparam logic [9:0]    LINES_TOTAL = 10'(TOTAL_LINES);
    localparam logic [9:0]    PRELOAD_N   = 10'(PRELOAD_LINES);
    localparam logic [9:0]    ROWS_N      = 10'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_WAIT_CREDIT,
        S_SEND_LINE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [9:0]    lines_q, lines_d;
    logic [2:0]    credit_q, credit_d;
    logic [9:0]    rows_q, rows_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    logic sending, pad_line, accept, beat, line_end, credit_inc, credit_dec;

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        lines_d    = lines_q;
        credit_d   = credit_q;
        rows_d     = rows_q;
        credit_dec = 1'b0;

        sending = (state_q == S_PRELOAD) || (state_q == S_SEND_LINE);
`ifdef LINE_FEED_PAD_EN
        pad_line = sending && ((lines_q == 10'd0) || (lines_q == 10'(IMG_H + 1)));
`else
        pad_line = 1'b0;
`endif
        o_src_ready = sending && !pad_line;
        accept      = i_src_valid && o_src_ready;
        beat        = accept || pad_line;
        line_end    = beat && (pix_q == PIX_LAST);
        credit_inc  = i_lb_intr && (state_q != S_IDLE);

        data_d  = pad_line ? 8'd0 : (accept ? i_src_data : data_q);
        valid_d = beat;

        if (beat) begin
            pix_d = line_end ? '0 : pix_q + PW'(1);
        end
        if (line_end) begin
            lines_d = lines_q + 10'd1;
        end
        if (credit_inc) begin
            rows_d = rows_q + 10'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_PRELOAD;
                    pix_d   = '0;
                    lines_d = '0;
                    rows_d  = '0;
                end
            end
            S_PRELOAD: begin
                if (line_end && (lines_d == PRELOAD_N)) begin
                    state_d = S_WAIT_CREDIT;
                end
            end
            S_WAIT_CREDIT: begin
                // Completion outranks draining; draining outranks spending a credit.
                if (rows_q == ROWS_N) begin
                    state_d = S_DONE;
                end else if (lines_q == LINES_TOTAL) begin
                    state_d = S_WAIT_CREDIT;
                end else if (credit_q != 3'd0) begin
                    state_d    = S_SEND_LINE;
                    credit_dec = 1'b1;
                end
            end
            S_SEND_LINE: begin
                if (line_end) begin
                    state_d = S_WAIT_CREDIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_IDLE) begin
            credit_d = i_start ? 3'd0 : credit_q;
        end else if (credit_inc && !credit_dec && (credit_q != 3'd7)) begin
            credit_d = credit_q + 3'd1;
        end else if (credit_dec && !credit_inc) begin
            credit_d = credit_q - 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            pix_q    <= '0;
            lines_q  <= '0;
            credit_q <= '0;
            rows_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            lines_q  <= lines_d;
            credit_q <= credit_d;
            rows_q   <= rows_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_lines_sent       = lines_q;
    assign o_busy             = (state_q != S_IDLE);
    assign o_done             = (state_q == S_DONE);

endmodule

// File: tb/tb_line_feed_ctrl.sv
// Directed bench for line_feed_ctrl with an 8x6 image and 4 preload lines (no padding build).
module tb_line_feed_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_src_data;
    logic       i_src_valid;
    logic       o_src_ready;
    logic [7:0] o_pixel_data;
    logic       o_pixel_data_valid;
    logic       i_lb_intr;
    logic       o_busy;
    logic       o_done;
    logic [9:0] o_lines_sent;

    int   tests       = 0;
    int   failed      = 0;
    int   phase_beats = 0;
    int   done_cnt    = 0;
    int   cyc_n       = 0;
    int   first_beat  = 0;
    int   last_beat   = 0;
    logic [7:0] exp_data = 8'h00;
    logic rand_valid = 1'b0;

    always #5 i_clk = ~i_clk;

    line_feed_ctrl #(
        .IMG_W        (8),
        .IMG_H        (6),
        .PRELOAD_LINES(4)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_src_data        (i_src_data),
        .i_src_valid       (i_src_valid),
        .o_src_ready       (o_src_ready),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .i_lb_intr         (i_lb_intr),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_lines_sent      (o_lines_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the source on accept, check output order, count beats and done pulses.
    task automatic tick();
        logic acc;
        acc = i_src_valid && o_src_ready && !i_rst;
        @(posedge i_clk);
        #1;
        cyc_n++;
        if (acc) i_src_data = i_src_data + 8'd1;
        if (o_pixel_data_valid === 1'b1) begin
            check("data_order", {24'd0, o_pixel_data}, {24'd0, exp_data});
            exp_data = exp_data + 8'd1;
            if (phase_beats == 0) first_beat = cyc_n;
            last_beat = cyc_n;
            phase_beats++;
        end
        if (o_done === 1'b1) done_cnt++;
        if (rand_valid) i_src_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_intr();
        i_lb_intr = 1'b1;
        tick();
        i_lb_intr = 1'b0;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_start     = 1'b1;
        i_src_valid = 1'b1;
        i_src_data  = 8'h10;
        i_lb_intr   = 1'b0;

        // Reset with valid source and start held high
        repeat (3) tick();
        check("rst_valid", {31'd0, o_pixel_data_valid}, 32'd0);
        check("rst_data", {24'd0, o_pixel_data}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_ready", {31'd0, o_src_ready}, 32'd0);
        check("rst_lines", {22'd0, o_lines_sent}, 32'd0);
        i_rst   = 1'b0;
        i_start = 1'b0;
        tick();
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_ready", {31'd0, o_src_ready}, 32'd0);

        // Preload: 4 lines of 8, one-cycle latency, contiguous, no extra beat
        exp_data    = i_src_data;
        phase_beats = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("pre_latency_valid", {31'd0, o_pixel_data_valid}, 32'd0);
        check("pre_ready", {31'd0, o_src_ready}, 32'd1);
        check("pre_busy", {31'd0, o_busy}, 32'd1);
        repeat (39) tick();
        check("pre_beats", phase_beats, 32);
        check("pre_contiguous", last_beat - first_beat, 31);
        check("pre_lines", {22'd0, o_lines_sent}, 32'd4);
        check("pre_ready_low", {31'd0, o_src_ready}, 32'd0);

        // Credit flow with a gappy source; second credit arrives mid-line
        rand_valid  = 1'b1;
        phase_beats = 0;
        pulse_intr();
        for (int k = 0; k < 200 && phase_beats < 3; k++) tick();
        check("mid_beats", phase_beats, 3);
        check("mid_lines", {22'd0, o_lines_sent}, 32'd4);
        pulse_intr();
        for (int k = 0; k < 200 && o_lines_sent != 10'd5; k++) tick();
        check("line5_lines", {22'd0, o_lines_sent}, 32'd5);
        check("line5_beats", phase_beats, 8);
        for (int k = 0; k < 200 && o_lines_sent != 10'd6; k++) tick();
        check("line6_lines", {22'd0, o_lines_sent}, 32'd6);
        check("line6_beats", phase_beats, 16);
        rand_valid  = 1'b0;
        i_src_valid = 1'b1;
        repeat (4) tick();
        check("drain_beats", phase_beats, 16);
        check("drain_ready", {31'd0, o_src_ready}, 32'd0);
        check("drain_busy", {31'd0, o_busy}, 32'd1);

        // Completion after the 4th credit
        pulse_intr();
        repeat (2) tick();
        check("row3_done", {31'd0, o_done}, 32'd0);
        check("row3_lines", {22'd0, o_lines_sent}, 32'd6);
        pulse_intr();
        check("row4_done_early", {31'd0, o_done}, 32'd0);
        tick();
        check("done_pulse", {31'd0, o_done}, 32'd1);
        check("done_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check("after_done", {31'd0, o_done}, 32'd0);
        check("after_busy", {31'd0, o_busy}, 32'd0);
        pulse_intr();
        tick();
        check("extra_intr_busy", {31'd0, o_busy}, 32'd0);
        check("done_count", done_cnt, 1);

        // Reset in SEND_LINE at pixel 3, then restart
        exp_data = i_src_data;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (36) tick();
        check("re_pre_lines", {22'd0, o_lines_sent}, 32'd4);
        pulse_intr();
        repeat (4) tick();
        check("send_ready", {31'd0, o_src_ready}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_lines", {22'd0, o_lines_sent}, 32'd0);
        check("abort_ready", {31'd0, o_src_ready}, 32'd0);
        check("abort_valid", {31'd0, o_pixel_data_valid}, 32'd0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 1);
        exp_data    = i_src_data;
        phase_beats = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (39) tick();
        check("restart_beats", phase_beats, 32);
        check("restart_lines", {22'd0, o_lines_sent}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/line_feed_ctrl.md
Name: line_feed_ctrl

Overview:
- Sequences the pixel stream from an upstream source (DMA/FIFO) into the 4-line, 3-row-window line buffer datapath.
- Preloads the first lines, then releases exactly one further line per line-done interrupt (i_lb_intr) from the line buffer block.
- Signals image completion once all output rows have been produced.
- Sits between the source stream and the line buffer input. Its only flow control is the interrupt-credit mechanism.

Parameters:
- IMG_W, 512, pixels per line; must equal the line buffer depth.
- IMG_H, 512, image lines; must be >= PRELOAD_LINES.
- PRELOAD_LINES, 4, lines pushed before waiting for credits; equals the number of line buffers.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle start pulse; ignored unless in IDLE.
- i_src_data  input  8  source pixel.
- i_src_valid  input  1  source pixel valid.
- o_src_ready  output  1  controller accepts a source pixel this cycle.
- o_pixel_data  output  8  pixel to the line buffer input.
- o_pixel_data_valid  output  1  pixel valid to the line buffer input.
- i_lb_intr  input  1  one-cycle pulse from the line buffer: one output row read, one buffer freed.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse: image complete.
- o_lines_sent  output  10  lines fully forwarded since start.

Behaviour:
Reset:
- State=IDLE. Pixel counter, line counter, credit counter and row counter = 0.
- o_pixel_data=0, o_pixel_data_valid=0, o_done=0, o_busy=0, o_src_ready=0.
- Reset mid-image aborts immediately. No partial line is completed and no o_done is issued.

Datapath:
- Accept = i_src_valid & o_src_ready.
- o_src_ready is combinational from state: high only in PRELOAD and SEND_LINE.
- Registered output stage, 1-cycle latency: o_pixel_data <= i_src_data and o_pixel_data_valid <= accept on each edge.
- o_pixel_data holds its last value when not valid.

Counters:
- Pixel counter counts accepts, 0..IMG_W-1, and wraps to 0 on the last pixel of a line.
- o_lines_sent increments on the accept of pixel IMG_W-1.
- o_src_ready drops in the cycle after the last accept, so exactly IMG_W pixels are forwarded per line; there is never an extra beat.

Credit counter (3 bits):
- +1 on each i_lb_intr, -1 on entering SEND_LINE from WAIT_CREDIT.
- Both in the same cycle: value unchanged.
- Saturates at 7. Saturation is unreachable in legal operation.
- i_lb_intr is counted in every non-IDLE state, including during PRELOAD and SEND_LINE.

Row counter:
- +1 per i_lb_intr.
- Expected output rows R = IMG_H-2 (no padding).

States:
- IDLE: i_start -> PRELOAD; counters and credits cleared on that edge.
- PRELOAD: forward lines. When o_lines_sent reaches PRELOAD_LINES -> WAIT_CREDIT.
- WAIT_CREDIT, priority order:
  - If row counter == R -> DONE.
  - Else if o_lines_sent == IMG_H -> stay (drain; wait for remaining i_lb_intr).
  - Else if credit > 0 -> SEND_LINE, credit-1.
- SEND_LINE: forward one line -> WAIT_CREDIT.
- DONE: o_done=1 for one cycle -> IDLE. o_busy falls on the IDLE entry edge.

Optional Feature:
Macro LINE_FEED_PAD_EN.
- Defined:
  - One all-zero line is injected before source line 0, and one after source line IMG_H-1.
  - Injected lines take IMG_W cycles with o_pixel_data=0, o_pixel_data_valid=1 and o_src_ready=0.
  - Injected lines count in o_lines_sent; the total forwarded is IMG_H+2.
  - R = IMG_H, giving same-size filter output.
  - The top pad is part of the preload.
  - The bottom pad needs a credit like any other line.
- Undefined: no padding; forwarded lines = IMG_H, R = IMG_H-2.

Test Plan:
- Reset/idle: assert i_rst 3 cycles with i_src_valid=1 -> all outputs 0, o_src_ready=0; i_start during reset ignored.
- Preload: IMG_W=8, IMG_H=6, source always valid, i_start -> 32 consecutive o_pixel_data_valid beats, data = source order delayed 1 cycle, o_lines_sent=4, then o_src_ready=0 with no extra beat.
- Credit flow:
  - After preload, pulse i_lb_intr once -> exactly 8 more beats, o_lines_sent=5.
  - Second pulse arriving mid-line -> a further line follows immediately, o_lines_sent=6, no pulse lost.
- Completion: IMG_H=6, issue 4 i_lb_intr total -> o_done single-cycle pulse after the 4th, o_busy falls the next cycle; a 5th intr pulse has no effect.
- Backpressure/valid gaps: i_src_valid toggling 1-0-1 randomly -> output beat count per line still 8; the data sequence is unbroken and in order.
- Reset mid-SEND_LINE at pixel 3 -> next cycle IDLE, counters 0, o_done never pulses; a fresh i_start restarts the preload from line 0.
